// File: rtl/control_sumador.sv
// Shares one saturating adder between two requesters with round-robin arbitration.
// REQ seen in IDLE -> ACK three cycles later; a requester keeps REQ/A/B held until its ACK, then must drop REQ.
module control_sumador #(
    parameter int Width = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             REQ0,
    input  logic [Width-1:0] A0,
    input  logic [Width-1:0] B0,
    input  logic             REQ1,
    input  logic [Width-1:0] A1,
    input  logic [Width-1:0] B1,
    output logic             ACK0,
    output logic             ACK1,
    output logic             GNT,
    output logic             OCUPADO,
    output logic [Width-1:0] Y,
    output logic             SAT,
    output logic             N
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CARGA   = 3'd1,
        SUMA    = 3'd2,
        ENTREGA = 3'd3,
        ESPERA  = 3'd4
    } estado_t;

    localparam logic [Width-1:0] YMAX = {1'b0, {(Width-1){1'b1}}};
    localparam logic [Width-1:0] YMIN = {1'b1, {(Width-1){1'b0}}};

    estado_t           estado;
    estado_t           siguiente;
    logic              pri;
    logic              sel;
    logic              req_gnt;
    logic [Width-1:0]  aop;
    logic [Width-1:0]  bop;
    logic signed [Width:0] suma;

    assign req_gnt = GNT ? REQ1 : REQ0;
    assign suma    = $signed({aop[Width-1], aop}) + $signed({bop[Width-1], bop});

    always_comb begin
        siguiente = estado;
        sel       = GNT;
        case (estado)
            IDLE: begin
                if (REQ0 || REQ1) begin
                    siguiente = CARGA;
                    sel       = (REQ0 && REQ1) ? pri : REQ1;
                end
            end
            CARGA:   siguiente = SUMA;
            SUMA:    siguiente = ENTREGA;
            ENTREGA: siguiente = ESPERA;
            ESPERA:  if (!req_gnt) siguiente = IDLE;
            // Unused encodings recover to IDLE without emitting an ACK.
            default: siguiente = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            estado  <= IDLE;
            pri     <= 1'b0;
            GNT     <= 1'b0;
            ACK0    <= 1'b0;
            ACK1    <= 1'b0;
            OCUPADO <= 1'b0;
            Y       <= '0;
            SAT     <= 1'b0;
            N       <= 1'b0;
            aop     <= '0;
            bop     <= '0;
        end else begin
            estado  <= siguiente;
            OCUPADO <= (siguiente != IDLE);
            ACK0    <= (siguiente == ENTREGA) && !GNT;
            ACK1    <= (siguiente == ENTREGA) && GNT;
            if (estado == IDLE && siguiente == CARGA) begin
                GNT <= sel;
                pri <= ~sel;
            end
            if (estado == CARGA) begin
                aop <= GNT ? A1 : A0;
                bop <= GNT ? B1 : B0;
            end
            // Result stays put from one SUMA to the next.
            if (estado == SUMA) begin
                if (suma > $signed({YMAX[Width-1], YMAX})) begin
                    Y   <= YMAX;
                    SAT <= 1'b1;
                    N   <= 1'b0;
                end else if (suma < $signed({YMIN[Width-1], YMIN})) begin
                    Y   <= YMIN;
                    SAT <= 1'b1;
                    N   <= 1'b1;
                end else begin
                    Y   <= suma[Width-1:0];
                    SAT <= 1'b0;
                    N   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_control_sumador.sv
// Directed bench for control_sumador; expected responses go to a scoreboard queue checked on each ACK.
module tb_control_sumador;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       REQ0 = 1'b0, REQ1 = 1'b0;
    logic [3:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
    logic       ACK0, ACK1, GNT, OCUPADO, SAT, N;
    logic [3:0] Y;

    typedef struct {
        bit       who;
        bit [3:0] y;
        bit       sat;
        bit       n;
        int       cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    control_sumador #(.Width(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ0(REQ0), .A0(A0), .B0(B0),
        .REQ1(REQ1), .A1(A1), .B1(B1),
        .ACK0(ACK0), .ACK1(ACK1), .GNT(GNT), .OCUPADO(OCUPADO),
        .Y(Y), .SAT(SAT), .N(N)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every ACK pops one expectation.
    always @(negedge CLK) begin
        if (RST_N && (ACK0 || ACK1)) begin
            exp_t e;
            chk("ack_exclusive", int'(ACK0 & ACK1), 0);
            if (sb.size() == 0) begin
                chk("unexpected_ack", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("ack_who", int'(ACK1), int'(e.who));
                chk("gnt", int'(GNT), int'(e.who));
                chk("y", int'(Y), int'(e.y));
                chk("sat", int'(SAT), int'(e.sat));
                if (e.sat) chk("n", int'(N), int'(e.n));
                chk("ocupado_at_ack", int'(OCUPADO), 1);
                if (e.cyc >= 0) chk("latency", cyc, e.cyc);
            end
        end
    end

    task automatic push(input bit who, input bit [3:0] y, input bit s, input bit n, input int c);
        exp_t e;
        e.who = who; e.y = y; e.sat = s; e.n = n; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input bit who);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK);
            if (who ? ACK1 : ACK0) seen = 1;
        end
        if (!seen) chk(who ? "timeout_ack1" : "timeout_ack0", 0, 1);
    endtask

    task automatic drop(input bit who);
        @(posedge CLK); #1;
        if (who) REQ1 = 1'b0; else REQ0 = 1'b0;
    endtask

    task automatic serve(input bit who, input bit [3:0] a, input bit [3:0] b,
                         input bit [3:0] y, input bit s, input bit n);
        @(posedge CLK); #1;
        if (who) begin A1 = a; B1 = b; REQ1 = 1'b1; end
        else     begin A0 = a; B0 = b; REQ0 = 1'b1; end
        push(who, y, s, n, cyc + 3);
        wait_ack(who);
        drop(who);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        bit bad;
        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ack0", int'(ACK0), 0);
        chk("rst_ack1", int'(ACK1), 0);
        chk("rst_ocupado", int'(OCUPADO), 0);
        chk("rst_gnt", int'(GNT), 0);
        chk("rst_y", int'(Y), 0);
        chk("rst_sat", int'(SAT), 0);
        chk("rst_n", int'(N), 0);
        RST_N = 1'b1;

        // Both at once after reset: 0 first, then 1 five cycles later
        @(posedge CLK); #1;
        A0 = 4'b0011; B0 = 4'b0010; A1 = 4'b0101; B1 = 4'b0110;
        REQ0 = 1'b1; REQ1 = 1'b1;
        k = cyc;
        push(1'b0, 4'b0101, 1'b0, 1'b0, k + 3);
        push(1'b1, 4'b0111, 1'b1, 1'b0, k + 8);
        wait_ack(1'b0);
        drop(1'b0);
        wait_ack(1'b1);
        drop(1'b1);

        // Re-request from 0, negative saturation
        serve(1'b0, 4'b1011, 4'b1010, 4'b1000, 1'b1, 1'b1);

        // Pointer now favours 1
        @(posedge CLK); #1;
        A0 = 4'b1000; B0 = 4'b0111; A1 = 4'b0111; B1 = 4'b0001;
        REQ0 = 1'b1; REQ1 = 1'b1;
        k = cyc;
        push(1'b1, 4'b0111, 1'b1, 1'b0, k + 3);
        push(1'b0, 4'b1111, 1'b0, 1'b0, k + 8);
        wait_ack(1'b1);
        drop(1'b1);
        wait_ack(1'b0);
        drop(1'b0);

        // Boundaries
        serve(1'b0, 4'b0111, 4'b0000, 4'b0111, 1'b0, 1'b0);
        serve(1'b1, 4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b0);
        serve(1'b0, 4'b1000, 4'b1111, 4'b1000, 1'b1, 1'b1);
        serve(1'b1, 4'b0100, 4'b1100, 4'b0000, 1'b0, 1'b0);

        // Other requester glitches mid-transaction; operands change after CARGA
        @(posedge CLK); #1;
        A0 = 4'b0001; B0 = 4'b0001; REQ0 = 1'b1;
        push(1'b0, 4'b0010, 1'b0, 1'b0, cyc + 3);
        @(posedge CLK); #1;
        REQ1 = 1'b1;
        @(posedge CLK); #1;
        REQ1 = 1'b0; A0 = 4'b0111; B0 = 4'b0111;
        wait_ack(1'b0);
        drop(1'b0);

        // Held request: one ACK, stays busy until REQ drops
        @(posedge CLK); #1;
        A0 = 4'b0010; B0 = 4'b0010; REQ0 = 1'b1;
        push(1'b0, 4'b0100, 1'b0, 1'b0, cyc + 3);
        wait_ack(1'b0);
        bad = 0;
        repeat (16) begin
            @(negedge CLK);
            if (!OCUPADO) bad = 1;
        end
        chk("hold_ocupado", int'(bad), 0);
        @(posedge CLK); #1;
        REQ0 = 1'b0;
        repeat (2) @(negedge CLK);
        chk("hold_release_ocupado", int'(OCUPADO), 0);

        // Reset during SUMA aborts, then the pending request is served afresh
        @(posedge CLK); #1;
        A0 = 4'b0001; B0 = 4'b0010; REQ0 = 1'b1;
        @(posedge CLK);
        @(posedge CLK); #1;
        RST_N = 1'b0;
        #1;
        chk("abort_ack0", int'(ACK0), 0);
        chk("abort_y", int'(Y), 0);
        chk("abort_ocupado", int'(OCUPADO), 0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        push(1'b0, 4'b0011, 1'b0, 1'b0, cyc + 3);
        wait_ack(1'b0);
        drop(1'b0);

        repeat (4) @(posedge CLK);
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
